// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified instruction/data RAM arbiter.
//   - arb_state_e : FSM state encoding, also exported on arb_state
//   - gnt_e       : which requester owns the current access
//   - RD_LAT_*    : legal RAM read-latency range and counter width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  // Wide enough to hold RD_LAT_MAX-1.
  localparam int unsigned LAT_CNT_W  = 2;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/arb_streak_guard.sv
// Fetch-starvation guard for the RAM arbiter.
// Owns the count of consecutive contended data grants and selects the
// requester to be granted on the next grant strobe.
//   SYS_clk, SYS_reset : clock, synchronous active-high reset
//   if_req, d_req      : live request lines
//   gnt_stb            : high in the cycle a grant is taken
//   sel_c              : selected requester (combinational)
module arb_streak_guard
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic SYS_clk,
  input  logic SYS_reset,
  input  logic if_req,
  input  logic d_req,
  input  logic gnt_stb,
  output gnt_e sel_c
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_full;

  assign streak_full = (streak_q == STREAK_W'(MAX_DATA_STREAK));

  // Data wins unless fetch is waiting and data has used up its streak.
  always_comb begin
    sel_c    = GNT_IF;
    streak_d = streak_q;
    if (d_req && !(if_req && streak_full)) begin
      sel_c = GNT_D;
    end
    if (gnt_stb) begin
      // Only data grants taken over a waiting fetch extend the streak.
      if ((sel_c == GNT_D) && if_req) begin
        streak_d = streak_full ? streak_q : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified RAM arbiter between fetch (read-only) and memory
// stage (read/write). Each access runs IDLE -> ACCESS -> [WAIT] -> DONE.
//   if_*  : fetch request/response, if_stall combinational
//   d_*   : data request/response, d_stall combinational
//   ram_* : fixed-latency RAM port, ram_en high one cycle per access
//   arb_state : current FSM state for debug display
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned RD_LAT          = 2,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        arb_state
);

  localparam int unsigned WA_W = ADDR_W - 2;

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT outside 1..4");
  end

  arb_state_e            state_q, state_d;
  gnt_e                  gnt_q, gnt_d, sel_c;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [WA_W-1:0]       addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                  if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic                  gnt_stb_c;
  logic                  unused_addr_lsbs;

  // Byte-offset bits carry no meaning for word accesses.
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  arb_streak_guard #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak_guard (
    .SYS_clk  (SYS_clk),
    .SYS_reset(SYS_reset),
    .if_req   (if_req),
    .d_req    (d_req),
    .gnt_stb  (gnt_stb_c),
    .sel_c    (sel_c)
  );

  // Next state, request latch, read capture and registered-output values.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    gnt_stb_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_stb_c = 1'b1;
          gnt_d     = sel_c;
          state_d   = ACCESS;
          if (sel_c == GNT_D) begin
            addr_d  = d_addr[ADDR_W-1:2];
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = if_addr[ADDR_W-1:2];
            we_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (gnt_q == GNT_D) begin
            d_rdata_d = ram_rdata;
          end else begin
            if_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Strobes are registered, so derive them from the state being entered.
    ram_en_d   = (state_d == ACCESS);
    ram_we_d   = (state_d == ACCESS) && we_d;
    if_valid_d = (state_d == DONE) && (gnt_d == GNT_IF);
    d_valid_d  = (state_d == DONE) && (gnt_d == GNT_D);
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_stall   = d_req & ~d_valid_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner-case
// sequences and random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned MAXS   = 4;

  logic              SYS_clk = 1'b0;
  logic              SYS_reset;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, ram_rdata;
  logic [DATA_W-1:0] if_rdata, d_rdata, ram_wdata;
  logic              if_valid, if_stall, d_valid, d_stall, ram_en, ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [1:0]        arb_state;

  always #5 SYS_clk = ~SYS_clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .arb_state(arb_state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : ((32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000);
  endfunction

  // RAM with RD_LAT=2: data valid two cycles after the ram_en cycle, junk otherwise.
  logic [31:0] mem [64];
  logic [31:0] rd_p0, rd_p1;
  bit          ram_ready = 1'b0;
  always @(posedge SYS_clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rd_p0 <= (ram_en && !ram_we) ? mem[ram_addr] : 32'hBAD0_BAD0;
    rd_p1 <= rd_p0;
  end
  assign ram_rdata = rd_p1;

  // Transaction-level model: one access at a time, fixed latencies from grant.
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          model_init = 1'b0;
  bit          busy = 1'b0;
  int          g_cyc = 0;
  bit          g_d = 1'b0, g_we = 1'b0;
  logic [5:0]  g_addr = '0;
  logic [31:0] g_wdata = '0, g_rd = '0;
  int          streak = 0;
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
  logic [31:0] mem_model [64];
  bit          last_if_valid = 1'b0, last_d_valid = 1'b0;
  bit          glog [$];
  int          ram_en_cnt = 0, d_valid_cnt = 0;

  always @(negedge SYS_clk) begin : model
    int   lat;
    bit   en_now, done_now, ev_if, ev_d;
    logic [1:0] st;
    if (!model_init) begin
      for (int i = 0; i < 64; i++) mem_model[i] = init_word(i);
      model_init = 1'b1;
    end
    cyc++;
    lat      = g_we ? 2 : int'(RD_LAT) + 2;
    en_now   = busy && (cyc == g_cyc + 1);
    done_now = busy && (cyc == g_cyc + lat);
    if (!busy || cyc > g_cyc + lat) st = 2'd0;
    else if (en_now)               st = 2'd1;
    else if (done_now)             st = 2'd3;
    else                           st = 2'd2;
    ev_if = done_now && !g_d;
    ev_d  = done_now && g_d;
    if (done_now && !g_we) begin
      if (g_d) exp_d_rdata = g_rd;
      else     exp_if_rdata = g_rd;
    end
    if (chk_en) begin
      chk("arb_state", 32'(arb_state), 32'(st));
      chk("if_valid", 32'(if_valid), 32'(ev_if));
      chk("d_valid", 32'(d_valid), 32'(ev_d));
      chk("if_stall", 32'(if_stall), 32'(if_req && !ev_if));
      chk("d_stall", 32'(d_stall), 32'(d_req && !ev_d));
      chk("ram_en", 32'(ram_en), 32'(en_now));
      chk("ram_we", 32'(ram_we), 32'(en_now && g_we));
      if (en_now) begin
        chk("ram_addr", 32'(ram_addr), 32'(g_addr));
        if (g_we) chk("ram_wdata", ram_wdata, g_wdata);
      end
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
    end
    if (if_valid) glog.push_back(1'b0);
    if (d_valid)  glog.push_back(1'b1);
    ram_en_cnt    += int'(ram_en);
    d_valid_cnt   += int'(d_valid);
    last_if_valid = if_valid;
    last_d_valid  = d_valid;
    if (SYS_reset) begin
      busy = 1'b0;
      streak = 0;
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
    end else if ((!busy || cyc > g_cyc + lat) && (if_req || d_req)) begin
      g_d    = d_req && !(if_req && streak == int'(MAXS));
      streak = (g_d && if_req) ? streak + 1 : 0;
      g_cyc  = cyc;
      busy   = 1'b1;
      if (g_d) begin
        g_we = d_we; g_addr = d_addr[7:2]; g_wdata = d_wdata;
      end else begin
        g_we = 1'b0; g_addr = if_addr[7:2];
      end
      if (g_we) mem_model[g_addr] = g_wdata;
      else      g_rd = mem_model[g_addr];
    end
  end

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  task automatic run_one(input vec_t v, input string nm);
    int start, got;
    bit seen;
    logic [31:0] rd;
    seen = 1'b0; got = 0; rd = '0;
    tick();
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wd;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    start = cyc + 1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge SYS_clk);
      #1;
      if (v.is_d ? d_valid : if_valid) begin
        seen = 1'b1; got = cyc; rd = v.is_d ? d_rdata : if_rdata;
      end
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_latency"}, 32'(got - start), 32'(v.lat));
      if (!v.we) chk({nm, "_rdata"}, rd, v.rd);
    end
    tick();
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t tbl [7];
    bit   exp_order [10];
    int   dv, iv, s_en, s_dv;
    bit   d_done, i_done;

    tbl[0] = '{1'b0, 1'b0, 8'h10, 32'h0,         4, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 1'b1, 8'h20, 32'h1234_5678, 2, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 8'h20, 32'h0,         4, 32'h1234_5678};
    tbl[3] = '{1'b0, 1'b0, 8'h23, 32'h0,         4, 32'h1234_5678};
    tbl[4] = '{1'b1, 1'b1, 8'hFC, 32'hA5A5_A5A5, 2, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 8'hFD, 32'h0,         4, 32'hA5A5_A5A5};
    tbl[6] = '{1'b1, 1'b0, 8'h11, 32'h0,         4, 32'hDEAD_BEEF};
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    SYS_reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    SYS_reset = 1'b0;
    chk_en = 1'b1;
    @(negedge SYS_clk);
    #1;
    chk("reset_state", 32'(arb_state), 32'd0);
    chk("reset_if_rdata", if_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);

    for (int i = 0; i < 7; i++) run_one(tbl[i], $sformatf("vec%0d", i));

    // Contention: both requesters held, all reads.
    glog.delete();
    tick();
    if_req = 1'b1; if_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'hFC;
    for (int n = 0; n < 200 && glog.size() < 10; n++) begin
      @(negedge SYS_clk);
      #1;
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
    chk("contention_count", 32'(glog.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < glog.size()) chk($sformatf("contention_order%0d", i), 32'(glog[i]), 32'(exp_order[i]));

    // Simultaneous single reads: data first, fetch RD_LAT+3 cycles later.
    tick();
    if_req = 1'b1; if_addr = 8'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    dv = 0; iv = 0; d_done = 1'b0; i_done = 1'b0;
    for (int n = 0; n < 40 && !i_done; n++) begin
      @(negedge SYS_clk);
      #1;
      if (d_valid) begin
        dv = cyc; d_done = 1'b1;
        chk("simul_if_rdata_held", if_rdata, 32'hDEAD_BEEF);
        chk("simul_d_rdata", d_rdata, 32'hDEAD_BEEF);
      end
      if (if_valid) begin
        iv = cyc; i_done = 1'b1;
        chk("simul_if_rdata", if_rdata, 32'h1234_5678);
      end
      tick();
      if (d_done) d_req = 1'b0;
      if (i_done) if_req = 1'b0;
    end
    chk("simul_both_done", 32'(d_done && i_done), 32'd1);
    chk("simul_spacing", 32'(iv - dv), 32'(RD_LAT + 3));

    // Reset during WAIT of a read.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    tick();
    tick();
    SYS_reset = 1'b1; d_req = 1'b0;
    tick();
    SYS_reset = 1'b0;
    s_dv = d_valid_cnt;
    @(negedge SYS_clk);
    #1;
    chk("rst_state", 32'(arb_state), 32'd0);
    chk("rst_outputs", 32'({if_valid, d_valid, if_stall, d_stall, ram_en, ram_we}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    repeat (6) tick();
    chk("rst_no_valid", 32'(d_valid_cnt - s_dv), 32'd0);
    run_one(tbl[0], "post_rst");

    // Data request dropped one cycle after its grant.
    s_en = ram_en_cnt; s_dv = d_valid_cnt;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'hFC;
    tick();
    d_req = 1'b0;
    repeat (12) tick();
    chk("drop_ram_en_count", 32'(ram_en_cnt - s_en), 32'd1);
    chk("drop_d_valid_count", 32'(d_valid_cnt - s_dv), 32'd1);

    // Random traffic; requests held until their own valid.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (if_req && last_if_valid) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 8'($urandom);
      end
      if (d_req && last_d_valid) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 8'($urandom); d_wdata = $urandom;
      end else if (d_req && $urandom_range(0, 3) == 0) begin
        d_wdata = $urandom;
      end
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
